// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS-subset pipeline slice.
package mips_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Clearable up-counter with a terminal-count flag; used to bound how long a
// memory access may sit waiting for its acknowledge.
module mem_wait_counter #(
    parameter int CNT_W    = 5,
    parameter int TERMINAL = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count_r;

    // Count enabled cycles, restarting whenever the waiting phase is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Flag fires during the TERMINAL-th enabled cycle so the owner can leave on that edge.
    always_comb begin
        tc = en & (count_r == CNT_W'(TERMINAL - 1));
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage controller: word loads/stores over a req/ack data memory with
// upstream stall. Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  init_n,
    input  logic                  valid,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  MemReg,
    input  logic                  RegW,
    input  logic [WORD_W-1:0]     ALUresult,
    input  logic [WORD_W-1:0]     writeData,
    input  logic [REG_ADDR_W-1:0] RegDestination,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [WORD_W-1:0]     mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [WORD_W-1:0]     mem_rdata,
    output logic                  stall_o,
    output logic                  mem_err,
    output logic                  MemReg_o,
    output logic                  RegW_o,
    output logic [WORD_W-1:0]     dataRead_o,
    output logic [WORD_W-1:0]     ALUresult_o,
    output logic [REG_ADDR_W-1:0] RegDestination_o
);

    mem_state_e        state_r;
    logic [WORD_W-1:0] rdata_r;
    logic              aborted_r;
    logic              access_s;
    logic              illegal_s;
    logic              misaligned_s;
    logic              timeout_s;

    assign access_s     = valid & (MemRead ^ MemWrite);
    assign illegal_s    = valid & MemRead & MemWrite;
    assign misaligned_s = access_s & (ALUresult[1:0] != 2'b00);

`ifdef MEM_TIMEOUT_EN
    mem_wait_counter #(
        .CNT_W    ($clog2(TIMEOUT) + 1),
        .TERMINAL (TIMEOUT)
    ) u_wait_counter (
        .clk   (clk),
        .rst_n (init_n),
        .clr   (state_r != WAIT),
        .en    (state_r == WAIT),
        .tc    (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Access sequencing plus the registered memory-request outputs.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_r   <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {WORD_W{1'b0}};
            mem_wdata <= {WORD_W{1'b0}};
            rdata_r   <= {WORD_W{1'b0}};
            aborted_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    aborted_r <= 1'b0;
                    if (access_s && !misaligned_s) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite;
                        mem_addr  <= ALUresult;
                        mem_wdata <= writeData;
                        state_r   <= WAIT;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                WAIT: begin
                    // A same-cycle ack wins over the timeout.
                    if (mem_ack) begin
                        if (!mem_we) begin
                            rdata_r <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        state_r <= DONE;
                    end else if (timeout_s) begin
                        mem_req   <= 1'b0;
                        aborted_r <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DONE: begin
                    aborted_r <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    mem_req   <= 1'b0;
                    aborted_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    // MEM/WB-facing fields and stall; outstanding accesses present a bubble.
    always_comb begin
        stall_o          = 1'b0;
        mem_err          = 1'b0;
        RegW_o           = 1'b0;
        MemReg_o         = 1'b0;
        dataRead_o       = {WORD_W{1'b0}};
        ALUresult_o      = ALUresult;
        RegDestination_o = RegDestination;
        case (state_r)
            IDLE: begin
                if (illegal_s || misaligned_s) begin
                    mem_err = 1'b1;
                end else if (access_s) begin
                    stall_o = 1'b1;
                end else begin
                    RegW_o   = RegW & valid;
                    MemReg_o = MemReg & valid;
                end
            end
            WAIT: begin
                stall_o = 1'b1;
            end
            DONE: begin
                if (aborted_r) begin
                    mem_err = 1'b1;
                end else begin
                    RegW_o     = RegW & valid;
                    MemReg_o   = MemReg & valid;
                    dataRead_o = rdata_r;
                end
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed instructions, a reactive
// memory model that checks requests, and a monitor checking MEM/WB captures.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        init_n;
    logic        valid, MemRead, MemWrite, MemReg, RegW;
    logic [31:0] ALUresult, writeData;
    logic [4:0]  RegDestination;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall_o, mem_err, MemReg_o, RegW_o;
    logic [31:0] dataRead_o, ALUresult_o;
    logic [4:0]  RegDestination_o;

    typedef struct {
        logic        regW;
        logic        memReg;
        logic [31:0] dataRead;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    exp_t expQ[$];
    req_t reqQ[$];

    int          applied = 0;
    int          miscompares = 0;
    int          ackDelay = 0;
    logic [31:0] rdataNext = 32'd0;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk              (clk),
        .init_n           (init_n),
        .valid            (valid),
        .MemRead          (MemRead),
        .MemWrite         (MemWrite),
        .MemReg           (MemReg),
        .RegW             (RegW),
        .ALUresult        (ALUresult),
        .writeData        (writeData),
        .RegDestination   (RegDestination),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .stall_o          (stall_o),
        .mem_err          (mem_err),
        .MemReg_o         (MemReg_o),
        .RegW_o           (RegW_o),
        .dataRead_o       (dataRead_o),
        .ALUresult_o      (ALUresult_o),
        .RegDestination_o (RegDestination_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: acks after ackDelay WAIT cycles (0 = never) and checks each new request.
    initial begin : memModel
        int   waitCnt;
        req_t r;
        waitCnt = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (mem_req) begin
                waitCnt++;
                if (waitCnt == 1) begin
                    if (reqQ.size() == 0) begin
                        check("unexpected_mem_req", 32'd1, 32'd0);
                    end else begin
                        r = reqQ.pop_front();
                        check("req_addr", mem_addr, r.addr);
                        check("req_we", {31'd0, mem_we}, {31'd0, r.we});
                        check("req_wdata", mem_wdata, r.wdata);
                    end
                end
                if (ackDelay != 0 && waitCnt == ackDelay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdataNext;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    // Monitor: every non-stalled valid cycle is a MEM/WB capture.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (init_n && valid && !stall_o) begin
                if (expQ.size() == 0) begin
                    check("unexpected_capture", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    check("RegW_o", {31'd0, RegW_o}, {31'd0, e.regW});
                    check("MemReg_o", {31'd0, MemReg_o}, {31'd0, e.memReg});
                    check("dataRead_o", dataRead_o, e.dataRead);
                    check("ALUresult_o", ALUresult_o, e.alu);
                    check("RegDestination_o", {27'd0, RegDestination_o}, {27'd0, e.rd});
                    check("mem_err", {31'd0, mem_err}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic issue(input string tag, input logic mr, input logic mw, input logic mreg,
                         input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input int dly, input logic [31:0] rresp,
                         input logic [31:0] expData, input logic expRegW, input logic expMemReg,
                         input logic expErr, input int expStall);
        exp_t e;
        req_t r;
        int   stallCnt;
        valid = 1'b1; MemRead = mr; MemWrite = mw; MemReg = mreg; RegW = rw;
        ALUresult = addr; writeData = wd; RegDestination = rd;
        ackDelay = dly; rdataNext = rresp;
        e.regW = expRegW; e.memReg = expMemReg; e.dataRead = expData;
        e.alu = addr; e.rd = rd; e.err = expErr;
        expQ.push_back(e);
        if (expStall > 0) begin
            r.addr = addr; r.we = mw; r.wdata = wd;
            reqQ.push_back(r);
        end
        stallCnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall_o) begin
                stallCnt++;
                check({tag, "_bubble"}, {30'd0, RegW_o, MemReg_o}, 32'd0);
            end else begin
                break;
            end
        end
        check({tag, "_stall_cycles"}, stallCnt, expStall);
        @(posedge clk);
        #1;
    endtask

    initial begin
        init_n = 1'b0; valid = 1'b0; MemRead = 1'b1; MemWrite = 1'b0;
        MemReg = 1'b1; RegW = 1'b1; ALUresult = 32'h0000_0104;
        writeData = 32'h1111_1111; RegDestination = 5'd3;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        #12;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_outs", {28'd0, RegW_o, MemReg_o, stall_o, mem_err}, 32'd0);
        check("rst_dataRead", dataRead_o, 32'd0);
        @(negedge clk);
        init_n = 1'b1;
        @(posedge clk);
        #1;

        //    tag       MR    MW    MReg  RegW  addr          wdata         rd    k  rdata resp    expData       eRW   eMR   eErr stall
        issue("alu",    1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0,       5'd5, 1, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 0);
        issue("load1",  1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h1111_1111, 5'd8, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 3);
        issue("store1", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 5'd0, 1, 32'h5555_5555, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 2);
        issue("misal",  1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0,       5'd9, 1, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 0);
        issue("illegal",1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h2222_2222, 5'd4, 1, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 0);
        issue("load2",  1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0,       5'd31, 3, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b0, 4);
        issue("alu2",   1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,       5'd0, 1, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 0);

        // Reset in the middle of a load that never gets acknowledged.
        valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; MemReg = 1'b1; RegW = 1'b1;
        ALUresult = 32'h0000_0080; writeData = 32'h3333_3333; RegDestination = 5'd7;
        ackDelay = 0;
        begin
            req_t r;
            r.addr = 32'h0000_0080; r.we = 1'b0; r.wdata = 32'h3333_3333;
            reqQ.push_back(r);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        check("wait_req_held", {31'd0, mem_req}, 32'd1);
        #2 init_n = 1'b0;
        #1;
        check("rst_async_req_drop", {31'd0, mem_req}, 32'd0);
        valid = 1'b0;
        #1;
        check("rst_idle_no_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        init_n = 1'b1;
        @(posedge clk);
        #2;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("stale_ack_no_req", {31'd0, mem_req}, 32'd0);
        check("stale_ack_no_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk);
        #1;
        check("stale_ack_still_idle", {31'd0, mem_req}, 32'd0);

        // rdata_q must have been cleared by reset and untouched by the stale ack.
        issue("store2", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'hA5A5_5A5A, 5'd2, 1, 32'h7777_7777, 32'h0, 1'b0, 1'b0, 1'b0, 2);
`ifdef MEM_TIMEOUT_EN
        issue("timeout", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0060, 32'h0, 5'd6, 0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5);
`endif
        valid = 1'b0;
        repeat (3) @(posedge clk);
        check("exp_queue_drained", expQ.size(), 32'd0);
        check("req_queue_drained", reqQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench did not complete");
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage controller of the pipelined MIPS subset. It sits between the EX/MEM pipeline register and the MEM/WB register. It performs word loads and stores against a handshaked data memory and stalls the upstream pipeline while an access is outstanding. It presents the MemReg, RegW, dataRead, ALUresult and RegDestination fields that the MEM/WB register captures.

## Interface
- TIMEOUT, 16: cycles in WAIT without mem_ack before the access is aborted; only used with MEM_TIMEOUT_EN.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- init_n  in  1  asynchronous, active-low reset.
- valid  in  1  EX/MEM holds a real instruction; 0 means bubble.
- MemRead, MemWrite, MemReg, RegW  in  1 each  control fields from EX/MEM.
- ALUresult  in  32  effective address or ALU value.
- writeData  in  32  store data.
- RegDestination  in  5  destination register.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 for store, registered.
- mem_addr  out  32  word address, registered.
- mem_wdata  out  32  store data, registered.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  32  load data, valid with mem_ack.
- stall_o  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- mem_err  out  1  one-cycle pulse: misaligned, illegal or aborted access.
- MemReg_o, RegW_o  out  1 each  to MEM/WB.
- dataRead_o, ALUresult_o  out  32 each  to MEM/WB.
- RegDestination_o  out  5  to MEM/WB.

## Operation
- FSM states: IDLE, WAIT, DONE.
- Definitions:
  - access = valid & (MemRead ^ MemWrite).
  - illegal = valid & MemRead & MemWrite.
  - misaligned = access & (ALUresult[1:0] != 0).
- IDLE, no access:
  - Pass-through: outputs equal the inputs; RegW_o = RegW & valid.
  - dataRead_o = 0 and stall_o = 0.
- IDLE, illegal or misaligned:
  - No request is issued and there is no stall.
  - mem_err = 1 this cycle.
  - RegW_o = MemReg_o = 0.
- IDLE, legal access:
  - stall_o = 1 and a bubble is driven (RegW_o = MemReg_o = 0).
  - Next edge: mem_addr/mem_wdata/mem_we are latched, mem_req is set, and the FSM goes to WAIT.
- WAIT:
  - stall_o = 1, bubble driven, mem_req held at 1.
  - On mem_ack: mem_rdata is captured into rdata_q (stores leave rdata_q unchanged), mem_req clears, next state is DONE.
- DONE:
  - stall_o = 0.
  - Outputs come from the still-held EX/MEM inputs; dataRead_o = rdata_q.
  - Next edge returns to IDLE.
- mem_ack outside WAIT is ignored.
- Outputs after reset:
  - Registered outputs: mem_req = mem_we = 0, mem_addr = mem_wdata = 0.
  - Internal state: rdata_q = 0, state = IDLE.
  - Combinational outputs: with valid = 0, RegW_o = MemReg_o = 0, stall_o = 0, mem_err = 0.
- Reset asserted mid-access:
  - Immediate return to IDLE; mem_req drops asynchronously.
  - A pending ack is discarded.

## Timing
- Non-memory instruction: zero added latency; combinational path to MEM/WB.
- Memory access with ack after k cycles in WAIT (k ≥ 1):
  - stall_o is high for 1 + k cycles.
  - DONE is presented on cycle k + 1 after entry; MEM/WB samples at the end of DONE.
- mem_req rises one cycle after the access appears in IDLE and falls on the edge that samples mem_ack.
- stall_o is combinational from state and inputs. Upstream must hold EX/MEM stable while stall_o = 1 and during DONE.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A wait counter counts cycles in WAIT.
  - When it reaches TIMEOUT: mem_req drops, state goes to DONE, mem_err pulses, RegW_o = MemReg_o = 0 in DONE, dataRead_o = 0.
  - mem_ack arriving in the same cycle as the timeout takes priority (normal completion).
- MEM_TIMEOUT_EN undefined: no counter; WAIT persists until mem_ack; the TIMEOUT parameter is unused.

## Structure
- Shared package mips_pkg holds:
  - State enum (IDLE, WAIT, DONE).
  - Constants WORD_W = 32 and REG_ADDR_W = 5.
- Sub-module mem_wait_counter: clearable up-counter with a terminal-count flag; instantiated only under MEM_TIMEOUT_EN.
- Request registers and rdata_q are plain flops with asynchronous reset.

## Test plan
- ALU op (valid=1, RegW=1, ALUresult=0x0000_1234, RegDestination=5) -> same cycle RegW_o=1, ALUresult_o=0x1234, stall_o=0, mem_req never asserted.
- Load from 0x100, mem_rdata=0xDEADBEEF, ack on 2nd WAIT cycle -> stall_o high 3 cycles, mem_addr=0x100, mem_we=0, DONE shows dataRead_o=0xDEADBEEF, MemReg_o=1.
- Store 0xCAFEF00D to 0x200, ack on 1st WAIT cycle -> mem_we=1, mem_wdata=0xCAFEF00D, stall 2 cycles, RegW_o=0 throughout.
- Load from 0x102 -> mem_err pulse, no mem_req, RegW_o=0, stall_o=0.
- init_n pulled low in WAIT -> mem_req=0 immediately, state IDLE; a stale ack after reset release causes no output change.
- With MEM_TIMEOUT_EN and TIMEOUT=4, ack never arrives -> mem_req drops after 4 WAIT cycles, mem_err pulses, DONE with RegW_o=0.
